// File: rtl/add8u_meter_pkg.sv
// Shared definitions for the add8u approximate-adder error meter.
//   meter_state_e : controller states (IDLE / RUN / DRAIN / DONE)
//   DEF_*         : default parameter values used by the meter modules
//   sat_add       : saturating add shared by the unsigned accumulators and
//                   the optional signed bias accumulator (ERR_METER_BIAS_EN)
package add8u_meter_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_NUM_SAMPLES = 65536;
  localparam int unsigned DEF_ACC_W       = 40;

  // Working width of sat_add; accumulator widths up to SAT_W-2 are exact.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } meter_state_e;

  // Adds inc to acc and clamps to the range of a w-bit accumulator.
  // Unsigned operands must be zero-extended, signed ones sign-extended.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] acc,
    input logic [SAT_W-1:0] inc,
    input int unsigned      w,
    input logic             is_signed
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = $signed(acc) + $signed(inc);
    if (is_signed) begin
      hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
      lo = -hi - SAT_W'(1);
      if (sum > hi) begin
        sum = hi;
      end else if (sum < lo) begin
        sum = lo;
      end
    end else begin
      hi = (SAT_W'(1) << w) - SAT_W'(1);
      if (sum > hi) begin
        sum = hi;
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/add8u_err_stage.sv
// Stage 1 of the error meter: recomputes the exact sum of the operands and
// registers the absolute error of the approximate output against it.
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : discards the sample being captured this cycle
//   in_fire      : a sample is transferred this cycle
//   in_a, in_b   : adder operands
//   in_o         : approximate adder output
//   out_valid    : registered sample valid
//   out_abs_err  : registered |in_o - (in_a + in_b)|
//   out_err_neg  : registered sign of the error (only with ERR_METER_BIAS_EN)
module add8u_err_stage
  import add8u_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_fire,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_o,
  output logic             out_valid,
  output logic [WIDTH:0]   out_abs_err
`ifdef ERR_METER_BIAS_EN
  ,
  output logic             out_err_neg
`endif
);

  logic [WIDTH:0]          exact;
  logic signed [WIDTH+1:0] diff;
  logic signed [WIDTH+1:0] neg_diff;

  logic           valid_d,   valid_q;
  logic [WIDTH:0] abs_err_d, abs_err_q;
  logic           err_neg_d, err_neg_q;

  always_comb begin
    exact     = {1'b0, in_a} + {1'b0, in_b};
    diff      = $signed({1'b0, in_o}) - $signed({1'b0, exact});
    neg_diff  = -diff;
    valid_d   = in_fire && !flush;
    err_neg_d = diff[WIDTH+1];
    abs_err_d = err_neg_d ? neg_diff[WIDTH:0] : diff[WIDTH:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      abs_err_q <= '0;
      err_neg_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      abs_err_q <= abs_err_d;
      err_neg_q <= err_neg_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_abs_err = abs_err_q;
`ifdef ERR_METER_BIAS_EN
  assign out_err_neg = err_neg_q;
`endif

endmodule

// File: rtl/add8u_err_meter.sv
// Streaming error meter for WIDTH-bit unsigned approximate adders.
// Accepts (a, b, o) samples over valid/ready, and accumulates the error
// count, sum of |error|, sum of error^2 and worst-case |error| over a run of
// NUM_SAMPLES samples. Optional macro ERR_METER_BIAS_EN adds a signed
// sum-of-error output sum_bias.
//   clk, rst_n          : clock, synchronous active-low reset
//   start / clear       : begin a run (IDLE/DONE) / abort and zero results
//   in_valid / in_ready : sample handshake
//   in_a, in_b, in_o    : operands and approximate sum
//   busy / done         : run in progress / results final
//   n_samples, err_cnt  : accumulated samples / samples with nonzero error
//   sum_abs, sum_sq     : saturating sums of |err| and err^2
//   wce                 : worst-case |err|
//   sum_bias            : saturating signed sum of err (ERR_METER_BIAS_EN)
module add8u_err_meter
  import add8u_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int unsigned ACC_W       = DEF_ACC_W,
  parameter int unsigned CNT_W       = 2 * WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [WIDTH:0]    in_o,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  n_samples,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ACC_W-1:0]  sum_abs,
  output logic [ACC_W-1:0]  sum_sq,
  output logic [WIDTH:0]    wce
`ifdef ERR_METER_BIAS_EN
  ,
  output logic signed [ACC_W-1:0] sum_bias
`endif
);

  localparam int unsigned      SQ_W  = 2 * WIDTH + 2;
  localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_SAMPLES);

  meter_state_e state_d, state_q;

  logic             s1_valid;
  logic [WIDTH:0]   s1_abs_err;
  logic             fire;
  logic             restart;
  logic [SQ_W-1:0]  sq;
  logic [SAT_W-1:0] sat_abs;
  logic [SAT_W-1:0] sat_sq;

  logic [CNT_W-1:0] acc_cnt_d,   acc_cnt_q;
  logic [CNT_W-1:0] n_samples_d, n_samples_q;
  logic [CNT_W-1:0] err_cnt_d,   err_cnt_q;
  logic [ACC_W-1:0] sum_abs_d,   sum_abs_q;
  logic [ACC_W-1:0] sum_sq_d,    sum_sq_q;
  logic [WIDTH:0]   wce_d,       wce_q;

`ifdef ERR_METER_BIAS_EN
  logic                    s1_err_neg;
  logic [SAT_W-1:0]        bias_inc;
  logic [SAT_W-1:0]        sat_bias;
  logic signed [ACC_W-1:0] sum_bias_d, sum_bias_q;
`endif

  add8u_err_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (clear),
    .in_fire    (fire),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_o       (in_o),
    .out_valid  (s1_valid),
    .out_abs_err(s1_abs_err)
`ifdef ERR_METER_BIAS_EN
    ,
    .out_err_neg(s1_err_neg)
`endif
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; clear overrides everything, start only acts from IDLE/DONE
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
        ST_RUN:           if (acc_cnt_q == NUM_C) state_d = ST_DRAIN;
        ST_DRAIN:         if (!s1_valid) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == ST_RUN) && (acc_cnt_q < NUM_C);
    busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done     = (state_q == ST_DONE);
  end

  // Stage 2: accumulators
  always_comb begin
    fire        = in_valid && in_ready;
    restart     = start && !clear && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    acc_cnt_d   = acc_cnt_q;
    n_samples_d = n_samples_q;
    err_cnt_d   = err_cnt_q;
    sum_abs_d   = sum_abs_q;
    sum_sq_d    = sum_sq_q;
    wce_d       = wce_q;
    sq          = SQ_W'(s1_abs_err) * SQ_W'(s1_abs_err);
    sat_abs     = sat_add(SAT_W'(sum_abs_q), SAT_W'(s1_abs_err), ACC_W, 1'b0);
    sat_sq      = sat_add(SAT_W'(sum_sq_q), SAT_W'(sq), ACC_W, 1'b0);
`ifdef ERR_METER_BIAS_EN
    bias_inc    = s1_err_neg ? -SAT_W'(s1_abs_err) : SAT_W'(s1_abs_err);
    sat_bias    = sat_add(SAT_W'(sum_bias_q), bias_inc, ACC_W, 1'b1);
    sum_bias_d  = sum_bias_q;
`endif
    if (clear || restart) begin
      acc_cnt_d   = '0;
      n_samples_d = '0;
      err_cnt_d   = '0;
      sum_abs_d   = '0;
      sum_sq_d    = '0;
      wce_d       = '0;
`ifdef ERR_METER_BIAS_EN
      sum_bias_d  = '0;
`endif
    end else begin
      if (fire) begin
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
      if (s1_valid) begin
        n_samples_d = n_samples_q + CNT_W'(1);
        if (s1_abs_err != '0) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        sum_abs_d = sat_abs[ACC_W-1:0];
        sum_sq_d  = sat_sq[ACC_W-1:0];
        if (s1_abs_err > wce_q) begin
          wce_d = s1_abs_err;
        end
`ifdef ERR_METER_BIAS_EN
        sum_bias_d = sat_bias[ACC_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt_q   <= '0;
      n_samples_q <= '0;
      err_cnt_q   <= '0;
      sum_abs_q   <= '0;
      sum_sq_q    <= '0;
      wce_q       <= '0;
`ifdef ERR_METER_BIAS_EN
      sum_bias_q  <= '0;
`endif
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      n_samples_q <= n_samples_d;
      err_cnt_q   <= err_cnt_d;
      sum_abs_q   <= sum_abs_d;
      sum_sq_q    <= sum_sq_d;
      wce_q       <= wce_d;
`ifdef ERR_METER_BIAS_EN
      sum_bias_q  <= sum_bias_d;
`endif
    end
  end

  assign n_samples = n_samples_q;
  assign err_cnt   = err_cnt_q;
  assign sum_abs   = sum_abs_q;
  assign sum_sq    = sum_sq_q;
  assign wce       = wce_q;
`ifdef ERR_METER_BIAS_EN
  assign sum_bias  = sum_bias_q;
`endif

endmodule

// File: tb/tb_add8u_err_meter.sv
module tb_add8u_err_meter;

  localparam int unsigned NI = 3;
  // Instance 0: exhaustive sweep, 1: single sample, 2: 1000-sample runs
  localparam int unsigned NS [NI] = '{65536, 1, 1000};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start    [NI];
  logic        clear    [NI];
  logic        in_valid [NI];
  logic        in_ready [NI];
  logic [7:0]  in_a     [NI];
  logic [7:0]  in_b     [NI];
  logic [8:0]  in_o     [NI];
  logic        busy     [NI];
  logic        done     [NI];
  logic [16:0] n_samples[NI];
  logic [16:0] err_cnt  [NI];
  logic [39:0] sum_abs  [NI];
  logic [39:0] sum_sq   [NI];
  logic [8:0]  wce      [NI];
`ifdef ERR_METER_BIAS_EN
  logic signed [39:0] sum_bias[NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    add8u_err_meter #(
      .WIDTH      (8),
      .NUM_SAMPLES(NS[g]),
      .ACC_W      (40),
      .CNT_W      (17)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[g]),
      .clear    (clear[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_a     (in_a[g]),
      .in_b     (in_b[g]),
      .in_o     (in_o[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .n_samples(n_samples[g]),
      .err_cnt  (err_cnt[g]),
      .sum_abs  (sum_abs[g]),
      .sum_sq   (sum_sq[g]),
      .wce      (wce[g])
`ifdef ERR_METER_BIAS_EN
      ,
      .sum_bias (sum_bias[g])
`endif
    );
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference statistics of the samples actually transferred
  longint exp_n, exp_err, exp_abs, exp_sq, exp_wce, exp_bias;

  task automatic model_clear();
    exp_n = 0; exp_err = 0; exp_abs = 0; exp_sq = 0; exp_wce = 0; exp_bias = 0;
  endtask

  task automatic model_add(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
    longint e, ae;
    e  = longint'(o) - (longint'(a) + longint'(b));
    ae = (e < 0) ? -e : e;
    exp_n++;
    if (ae != 0) exp_err++;
    exp_abs += ae;
    exp_sq  += ae * ae;
    if (ae > exp_wce) exp_wce = ae;
    exp_bias += e;
  endtask

  function automatic logic [122:0] exp_pack();
    return {17'(exp_n), 17'(exp_err), 40'(exp_abs), 40'(exp_sq), 9'(exp_wce)};
  endfunction

  function automatic logic [122:0] got_pack(input int g);
    return {n_samples[g], err_cnt[g], sum_abs[g], sum_sq[g], wce[g]};
  endfunction

  // mode 0: exact adder, 1: exhaustive index with O=(A+B)|1,
  // 2: random with occasional arbitrary O, 3: fixed A=200 B=100 O=292
  task automatic pick(input int g, input int mode, input int duty, input int idx);
    logic [15:0] ix;
    logic [8:0]  s;
    ix = 16'(idx);
    in_valid[g] = (int'($urandom_range(99)) < duty);
    case (mode)
      0: begin
        in_a[g] = 8'($urandom); in_b[g] = 8'($urandom);
        in_o[g] = {1'b0, in_a[g]} + {1'b0, in_b[g]};
      end
      1: begin
        in_a[g] = ix[7:0]; in_b[g] = ix[15:8];
        s = {1'b0, in_a[g]} + {1'b0, in_b[g]};
        in_o[g] = s | 9'd1;
      end
      2: begin
        in_a[g] = 8'($urandom); in_b[g] = 8'($urandom);
        s = {1'b0, in_a[g]} + {1'b0, in_b[g]};
        in_o[g] = ($urandom_range(3) == 0) ? 9'($urandom_range(511)) : s;
      end
      default: begin
        in_a[g] = 8'd200; in_b[g] = 8'd100; in_o[g] = 9'd292;
      end
    endcase
  endtask

  // Streams n samples into instance g; optionally pulses start once after
  // start_at transfers. Returns the posedge index of the last transfer.
  task automatic feed(input int g, input int n, input int mode, input int duty,
                      input int start_at, output int xfer_edge);
    int fed = 0;
    int guard = 0;
    bit injected = 0;
    xfer_edge = -1;
    pick(g, mode, duty, 0);
    while (fed < n && guard < 80000) begin
      if (in_valid[g] && in_ready[g]) begin
        model_add(in_a[g], in_b[g], in_o[g]);
        fed++;
        xfer_edge = cyc + 1;
      end
      if (start_at > 0 && fed == start_at && !injected) begin
        start[g] = 1'b1; injected = 1;
      end else begin
        start[g] = 1'b0;
      end
      @(negedge clk);
      guard++;
      pick(g, mode, duty, fed);
    end
    in_valid[g] = 1'b0;
    start[g] = 1'b0;
    n_checks++;
    if (fed != n) begin
      n_fail++;
      $display("FAIL feed_timeout inst %0d: transferred %0d, required %0d", g, fed, n);
    end
  endtask

  task automatic wait_done(input int g, output int seen);
    int guard = 0;
    seen = -1;
    while (done[g] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (done[g] === 1'b1) seen = cyc;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic test_reset();
    for (int g = 0; g < int'(NI); g++) begin
      n_checks++;
      if ({in_ready[g], busy[g], done[g]} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_flags inst %0d: got %b required 000", g, {in_ready[g], busy[g], done[g]});
      end
      n_checks++;
      if (got_pack(g) !== '0) begin
        n_fail++;
        $display("FAIL reset_results inst %0d: got %h required 0", g, got_pack(g));
      end
    end
  endtask

  task automatic test_exhaustive();
    int e, d;
    model_clear();
    pulse_start(0);
    n_checks++;
    if ({busy[0], in_ready[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL run_entry: got busy/ready %b required 11", {busy[0], in_ready[0]});
    end
    feed(0, 65536, 1, 100, 0, e);
    wait_done(0, d);
    n_checks++;
    if (d != e + 2) begin
      n_fail++;
      $display("FAIL exh_done_latency: done at edge %0d, required %0d", d, e + 2);
    end
    n_checks++;
    if (got_pack(0) !== exp_pack()) begin
      n_fail++;
      $display("FAIL exh_results: got %h required %h", got_pack(0), exp_pack());
    end
    n_checks++;
    if (err_cnt[0] !== 17'd32768 || wce[0] !== 9'd1) begin
      n_fail++;
      $display("FAIL exh_err_cnt_wce: got %0d/%0d required 32768/1", err_cnt[0], wce[0]);
    end
`ifdef ERR_METER_BIAS_EN
    n_checks++;
    if (sum_bias[0] !== 40'(exp_bias)) begin
      n_fail++;
      $display("FAIL exh_bias: got %0d required %0d", sum_bias[0], exp_bias);
    end
`endif
  endtask

  task automatic test_single();
    int e, d;
    model_clear();
    pulse_start(1);
    feed(1, 1, 3, 100, 0, e);
    n_checks++;
    if (in_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready_drop: got %b required 0", in_ready[1]);
    end
    @(negedge clk);
    n_checks++;
    if (got_pack(1) !== exp_pack()) begin
      n_fail++;
      $display("FAIL single_results: got %h required %h", got_pack(1), exp_pack());
    end
    n_checks++;
    if (sum_abs[1] !== 40'd8 || sum_sq[1] !== 40'd64 || wce[1] !== 9'd8) begin
      n_fail++;
      $display("FAIL single_values: got abs %0d sq %0d wce %0d required 8 64 8", sum_abs[1], sum_sq[1], wce[1]);
    end
    wait_done(1, d);
    n_checks++;
    if (d != e + 2) begin
      n_fail++;
      $display("FAIL single_done_latency: done at edge %0d, required %0d", d, e + 2);
    end
  endtask

  task automatic test_gaps();
    int e, d;
    model_clear();
    pulse_start(2);
    feed(2, 1000, 2, 50, 0, e);
    n_checks++;
    if (in_ready[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_ready_drop: got %b required 0", in_ready[2]);
    end
    in_valid[2] = 1'b1;
    wait_done(2, d);
    @(negedge clk);
    in_valid[2] = 1'b0;
    n_checks++;
    if (d != e + 2) begin
      n_fail++;
      $display("FAIL gaps_done_latency: done at edge %0d, required %0d", d, e + 2);
    end
    n_checks++;
    if (got_pack(2) !== exp_pack()) begin
      n_fail++;
      $display("FAIL gaps_results: got %h required %h", got_pack(2), exp_pack());
    end
`ifdef ERR_METER_BIAS_EN
    n_checks++;
    if (sum_bias[2] !== 40'(exp_bias)) begin
      n_fail++;
      $display("FAIL gaps_bias: got %0d required %0d", sum_bias[2], exp_bias);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int e, d;
    model_clear();
    pulse_start(2);
    n_checks++;
    if (got_pack(2) !== '0 || busy[2] !== 1'b1 || done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart_zero: got %h busy %b done %b required 0 1 0", got_pack(2), busy[2], done[2]);
    end
    feed(2, 1000, 0, 100, 0, e);
    wait_done(2, d);
    n_checks++;
    if (got_pack(2) !== exp_pack() || d != e + 2) begin
      n_fail++;
      $display("FAIL b2b_results: got %h at edge %0d required %h at edge %0d", got_pack(2), d, exp_pack(), e + 2);
    end
  endtask

  task automatic test_clear();
    int e;
    model_clear();
    pulse_start(2);
    feed(2, 500, 2, 70, 0, e);
    clear[2] = 1'b1;
    @(negedge clk);
    clear[2] = 1'b0;
    n_checks++;
    if ({in_ready[2], busy[2], done[2]} !== 3'b000 || got_pack(2) !== '0) begin
      n_fail++;
      $display("FAIL clear_abort: flags %b results %h required 000 and 0", {in_ready[2], busy[2], done[2]}, got_pack(2));
    end
    @(negedge clk);
    n_checks++;
    if (got_pack(2) !== '0) begin
      n_fail++;
      $display("FAIL clear_flush: got %h required 0", got_pack(2));
    end
  endtask

  task automatic test_start_in_run();
    int e, d;
    model_clear();
    pulse_start(2);
    feed(2, 1000, 2, 80, 300, e);
    wait_done(2, d);
    n_checks++;
    if (got_pack(2) !== exp_pack() || d != e + 2) begin
      n_fail++;
      $display("FAIL start_in_run: got %h at edge %0d required %h at edge %0d", got_pack(2), d, exp_pack(), e + 2);
    end
  endtask

  task automatic test_reset_drain();
    int e;
    model_clear();
    pulse_start(1);
    feed(1, 1, 2, 100, 0, e);
    @(negedge clk);
    n_checks++;
    if (busy[1] !== 1'b1 || done[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_state: busy %b done %b required 1 0", busy[1], done[1]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready[1], busy[1], done[1]} !== 3'b000 || got_pack(1) !== '0) begin
      n_fail++;
      $display("FAIL drain_reset: flags %b results %h required 000 and 0", {in_ready[1], busy[1], done[1]}, got_pack(1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < int'(NI); g++) begin
      start[g] = 1'b0; clear[g] = 1'b0; in_valid[g] = 1'b0;
      in_a[g] = '0; in_b[g] = '0; in_o[g] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_start_in_run();
    test_exhaustive();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
